// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Fetch-side branch prediction and execute-side branch resolution for NeoCore.
// A direct-mapped BTB holds {valid, tag, target, 2-bit counter} per index.
// Fetch looks up the BTB; execute resolves the branch condition, trains the
// BTB and raises a one-cycle redirect when the carried prediction was wrong.
//
// Ports:
//   clk, rst          single clock; synchronous active-high reset
//   f_valid, f_pc     fetch lookup request
//   p_valid, p_taken, p_target
//                     registered prediction (target is 0 unless taken)
//   r_valid, r_opcode, r_pc, r_next_pc, r_target,
//   r_operand_a, r_operand_b, r_v_flag, r_pred_taken, r_pred_target
//                     resolve request from execute
//   branch_taken      registered actual outcome
//   redirect, redirect_pc
//                     one-cycle mispredict pulse and the correct next PC
//   mispredict_count  saturating count of mispredicts
// -----------------------------------------------------------------------------
package neocore_pkg;
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_LD   = 4'd6,
        OP_ST   = 4'd7,
        OP_B    = 4'd8,
        OP_JSR  = 4'd9,
        OP_BE   = 4'd10,
        OP_BNE  = 4'd11,
        OP_BLT  = 4'd12,
        OP_BGT  = 4'd13,
        OP_BRO  = 4'd14,
        OP_HALT = 4'd15
    } opcode_e;
endpackage

module branch_predictor
    import neocore_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 16,
    parameter int BTB_ENTRIES = 16,
    parameter bit SIGNED_CMP  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    // fetch lookup
    input  logic              f_valid,
    input  logic [ADDR_W-1:0] f_pc,
    output logic              p_valid,
    output logic              p_taken,
    output logic [ADDR_W-1:0] p_target,
    // execute resolve
    input  logic              r_valid,
    input  opcode_e           r_opcode,
    input  logic [ADDR_W-1:0] r_pc,
    input  logic [ADDR_W-1:0] r_next_pc,
    input  logic [ADDR_W-1:0] r_target,
    input  logic [DATA_W-1:0] r_operand_a,
    input  logic [DATA_W-1:0] r_operand_b,
    input  logic              r_v_flag,
    input  logic              r_pred_taken,
    input  logic [ADDR_W-1:0] r_pred_target,
    output logic              branch_taken,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [15:0]       mispredict_count
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;

    // BTB storage
    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [1:0]             btb_ctr    [BTB_ENTRIES];
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [ADDR_W-1:0]      btb_target [BTB_ENTRIES];

    // -------------------------------------------------------------------------
    // Fetch lookup. Reads the array combinationally and registers the result,
    // so a same-cycle resolve write is not visible until the next lookup.
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic             f_predict;

    assign f_idx     = f_pc[IDX_W-1:0];
    assign f_tag     = f_pc[ADDR_W-1:IDX_W];
    assign f_hit     = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    assign f_predict = f_valid && f_hit && btb_ctr[f_idx][1];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of the order the blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid  <= 1'b0;
            p_taken  <= 1'b0;
            p_target <= '0;
        end else begin
            p_valid  <= f_valid;
            p_taken  <= f_predict;
            p_target <= f_predict ? btb_target[f_idx] : '0;
        end
    end

    // -------------------------------------------------------------------------
    // Resolve: branch condition evaluation
    // -------------------------------------------------------------------------
    logic is_branch;
    logic actual;
    logic cmp_lt;
    logic cmp_gt;

    assign cmp_lt = SIGNED_CMP ? ($signed(r_operand_a) < $signed(r_operand_b))
                               : (r_operand_a < r_operand_b);
    assign cmp_gt = SIGNED_CMP ? ($signed(r_operand_a) > $signed(r_operand_b))
                               : (r_operand_a > r_operand_b);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves a variable unassigned and infers a latch.
    always_comb begin
        is_branch = 1'b1;
        actual    = 1'b0;
        case (r_opcode)
            OP_B, OP_JSR: actual = 1'b1;
            OP_BE:        actual = (r_operand_a == r_operand_b);
            OP_BNE:       actual = (r_operand_a != r_operand_b);
            OP_BLT:       actual = cmp_lt;
            OP_BGT:       actual = cmp_gt;
            OP_BRO:       actual = r_v_flag;
            default:      is_branch = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Resolve: BTB training and mispredict detection
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             r_hit;
    logic             resolve;
    logic             mispredict;
    logic             btb_we;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_next;

    assign r_idx   = r_pc[IDX_W-1:0];
    assign r_tag   = r_pc[ADDR_W-1:IDX_W];
    assign r_hit   = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);
    assign ctr_cur = btb_ctr[r_idx];
    assign resolve = r_valid && is_branch;

    // Wrong direction, or right direction (taken) but to the wrong place.
    assign mispredict = (actual != r_pred_taken) ||
                        (actual && r_pred_taken && (r_pred_target != r_target));

    // A not-taken branch that misses the BTB leaves it untouched.
    assign btb_we = resolve && (actual || r_hit);

    always_comb begin
        ctr_next = ctr_cur;
        if (r_opcode == OP_B || r_opcode == OP_JSR) begin
            ctr_next = 2'b11;  // unconditional: always strongly taken
        end else if (actual) begin
            if (!r_hit)                ctr_next = 2'b10;  // fresh allocation
            else if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
        end else if (ctr_cur != 2'b00) begin
            ctr_next = ctr_cur - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_ctr[i] <= 2'b00;
            end
        end else if (btb_we) begin
            btb_valid[r_idx] <= 1'b1;
            btb_ctr[r_idx]   <= ctr_next;
        end
    end

    // NOTE: tag and target are deliberately not reset; a cleared valid bit
    // makes their contents irrelevant, so the wide arrays need no reset path.
    always_ff @(posedge clk) begin
        if (!rst && btb_we && actual) begin
            btb_tag[r_idx]    <= r_tag;
            btb_target[r_idx] <= r_target;
        end
    end

    // -------------------------------------------------------------------------
    // Registered resolve outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_taken     <= 1'b0;
            redirect         <= 1'b0;
            redirect_pc      <= '0;
            mispredict_count <= '0;
        end else begin
            branch_taken <= resolve && actual;
            redirect     <= resolve && mispredict;
            redirect_pc  <= (resolve && mispredict) ? (actual ? r_target : r_next_pc) : '0;
            if (resolve && mispredict && (mispredict_count != 16'hFFFF)) begin
                mispredict_count <= mispredict_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed table of single-cycle vectors for the named scenarios, a reset
// sequence, then randomized traffic checked against a behavioural BTB model.
// Two instances share all inputs: the unsigned-compare instance is the main
// one; the signed-compare instance is checked only on branch_taken.
// -----------------------------------------------------------------------------
module tb_branch_predictor;
    import neocore_pkg::*;

    localparam int AW = 32;
    localparam int DW = 16;
    localparam int NE = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_valid;
    logic [AW-1:0] f_pc;
    logic          r_valid;
    opcode_e       r_opcode;
    logic [AW-1:0] r_pc, r_next_pc, r_target, r_pred_target;
    logic [DW-1:0] r_operand_a, r_operand_b;
    logic          r_v_flag, r_pred_taken;

    logic          p_valid, p_taken, branch_taken, redirect;
    logic [AW-1:0] p_target, redirect_pc;
    logic [15:0]   mispredict_count;

    logic          s_p_valid, s_p_taken, s_branch_taken, s_redirect;
    logic [AW-1:0] s_p_target, s_redirect_pc;
    logic [15:0]   s_mispredict_count;

    always #5 clk = ~clk;

    branch_predictor #(.ADDR_W(AW), .DATA_W(DW), .BTB_ENTRIES(NE), .SIGNED_CMP(1'b0)) dut (
        .clk(clk), .rst(rst), .f_valid(f_valid), .f_pc(f_pc),
        .p_valid(p_valid), .p_taken(p_taken), .p_target(p_target),
        .r_valid(r_valid), .r_opcode(r_opcode), .r_pc(r_pc), .r_next_pc(r_next_pc),
        .r_target(r_target), .r_operand_a(r_operand_a), .r_operand_b(r_operand_b),
        .r_v_flag(r_v_flag), .r_pred_taken(r_pred_taken), .r_pred_target(r_pred_target),
        .branch_taken(branch_taken), .redirect(redirect), .redirect_pc(redirect_pc),
        .mispredict_count(mispredict_count)
    );

    branch_predictor #(.ADDR_W(AW), .DATA_W(DW), .BTB_ENTRIES(NE), .SIGNED_CMP(1'b1)) dut_s (
        .clk(clk), .rst(rst), .f_valid(f_valid), .f_pc(f_pc),
        .p_valid(s_p_valid), .p_taken(s_p_taken), .p_target(s_p_target),
        .r_valid(r_valid), .r_opcode(r_opcode), .r_pc(r_pc), .r_next_pc(r_next_pc),
        .r_target(r_target), .r_operand_a(r_operand_a), .r_operand_b(r_operand_b),
        .r_v_flag(r_v_flag), .r_pred_taken(r_pred_taken), .r_pred_target(r_pred_target),
        .branch_taken(s_branch_taken), .redirect(s_redirect), .redirect_pc(s_redirect_pc),
        .mispredict_count(s_mispredict_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus plus the outputs expected one edge later.
    typedef struct {
        string         nm;
        logic          rst;
        logic          fv;
        logic [AW-1:0] fpc;
        logic          rv;
        opcode_e       op;
        logic [AW-1:0] rpc, tgt, ptgt;
        logic [DW-1:0] a, b;
        logic          v, pt;
        logic          e_pv, e_pt;
        logic [AW-1:0] e_ptgt;
        logic          e_bt, e_bts, e_rd;
        logic [AW-1:0] e_rpc;
        logic [15:0]   e_cnt;
    } vec_t;

    function automatic vec_t lk(string nm, logic [AW-1:0] pc, logic e_pt,
                                logic [AW-1:0] e_ptgt, logic [15:0] cnt);
        vec_t t;
        t.nm = nm; t.rst = 1'b0; t.fv = 1'b1; t.fpc = pc;
        t.rv = 1'b0; t.op = OP_NOP; t.rpc = '0; t.tgt = '0; t.ptgt = '0;
        t.a = '0; t.b = '0; t.v = 1'b0; t.pt = 1'b0;
        t.e_pv = 1'b1; t.e_pt = e_pt; t.e_ptgt = e_ptgt;
        t.e_bt = 1'b0; t.e_bts = 1'b0; t.e_rd = 1'b0; t.e_rpc = '0; t.e_cnt = cnt;
        return t;
    endfunction

    function automatic vec_t rs(string nm, opcode_e op, logic [AW-1:0] pc, logic [AW-1:0] tgt,
                                logic [DW-1:0] a, logic [DW-1:0] b, logic v, logic pt,
                                logic [AW-1:0] ptgt, logic e_bt, logic e_bts, logic e_rd,
                                logic [AW-1:0] e_rpc, logic [15:0] cnt);
        vec_t t;
        t.nm = nm; t.rst = 1'b0; t.fv = 1'b0; t.fpc = '0;
        t.rv = 1'b1; t.op = op; t.rpc = pc; t.tgt = tgt; t.ptgt = ptgt;
        t.a = a; t.b = b; t.v = v; t.pt = pt;
        t.e_pv = 1'b0; t.e_pt = 1'b0; t.e_ptgt = '0;
        t.e_bt = e_bt; t.e_bts = e_bts; t.e_rd = e_rd; t.e_rpc = e_rpc; t.e_cnt = cnt;
        return t;
    endfunction

    task automatic apply(input vec_t t);
        rst           = t.rst;
        f_valid       = t.fv;
        f_pc          = t.fpc;
        r_valid       = t.rv;
        r_opcode      = t.op;
        r_pc          = t.rpc;
        r_next_pc     = t.rpc + 32'd4;
        r_target      = t.tgt;
        r_operand_a   = t.a;
        r_operand_b   = t.b;
        r_v_flag      = t.v;
        r_pred_taken  = t.pt;
        r_pred_target = t.ptgt;
        @(posedge clk);
        #1;
        check({t.nm, ".p_valid"},      {31'd0, p_valid},        {31'd0, t.e_pv});
        check({t.nm, ".p_taken"},      {31'd0, p_taken},        {31'd0, t.e_pt});
        check({t.nm, ".p_target"},     p_target,                t.e_ptgt);
        check({t.nm, ".branch_taken"}, {31'd0, branch_taken},   {31'd0, t.e_bt});
        check({t.nm, ".signed_taken"}, {31'd0, s_branch_taken}, {31'd0, t.e_bts});
        check({t.nm, ".redirect"},     {31'd0, redirect},       {31'd0, t.e_rd});
        if (t.e_rd) check({t.nm, ".redirect_pc"}, redirect_pc, t.e_rpc);
        check({t.nm, ".mispredicts"},  {16'd0, mispredict_count}, {16'd0, t.e_cnt});
    endtask

    // ---------------------------------------------------------------- model
    logic          m_valid [NE];
    logic [AW-1:0] m_tag   [NE];
    logic [AW-1:0] m_tgt   [NE];
    int            m_ctr   [NE];
    int            m_cnt;

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
        end
        m_cnt = 0;
    endtask

    function automatic int as_signed(logic [DW-1:0] x);
        return (x >= 16'h8000) ? int'(x) - 65536 : int'(x);
    endfunction

    function automatic bit model_hit(logic [AW-1:0] pc);
        return m_valid[pc % NE] && (m_tag[pc % NE] == pc / NE);
    endfunction

    task automatic model_step(input vec_t t, output vec_t r);
        int  idx;
        bit  br, tk, tks, hit, mis;
        r = t;
        if (t.rst) begin
            model_reset();
            r.e_pv = 0; r.e_pt = 0; r.e_ptgt = '0; r.e_bt = 0; r.e_bts = 0;
            r.e_rd = 0; r.e_rpc = '0; r.e_cnt = '0;
            return;
        end
        // Lookup sees the state before this cycle's update.
        idx    = int'(t.fpc % NE);
        r.e_pv = t.fv;
        r.e_pt = t.fv && model_hit(t.fpc) && (m_ctr[idx] >= 2);
        r.e_ptgt = r.e_pt ? m_tgt[idx] : '0;

        br = 1; tk = 0; tks = 0;
        case (t.op)
            OP_B, OP_JSR: begin tk = 1; tks = 1; end
            OP_BE:  begin tk = (t.a == t.b); tks = tk; end
            OP_BNE: begin tk = (t.a != t.b); tks = tk; end
            OP_BLT: begin tk = int'(t.a) < int'(t.b); tks = as_signed(t.a) < as_signed(t.b); end
            OP_BGT: begin tk = int'(t.a) > int'(t.b); tks = as_signed(t.a) > as_signed(t.b); end
            OP_BRO: begin tk = t.v; tks = t.v; end
            default: br = 0;
        endcase
        br = br && t.rv;
        mis = br && ((tk != t.pt) || (tk && t.pt && t.ptgt != t.tgt));
        r.e_bt  = br && tk;
        r.e_bts = br && tks;
        r.e_rd  = mis;
        r.e_rpc = tk ? t.tgt : t.rpc + 32'd4;
        if (mis && m_cnt < 65535) m_cnt++;
        r.e_cnt = m_cnt[15:0];

        idx = int'(t.rpc % NE);
        hit = model_hit(t.rpc);
        if (br && tk) begin
            if (t.op == OP_B || t.op == OP_JSR) m_ctr[idx] = 3;
            else if (hit)                       m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
            else                                m_ctr[idx] = 2;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = t.rpc / NE;
            m_tgt[idx]   = t.tgt;
        end else if (br && hit) begin
            m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
        end
    endtask

    // ---------------------------------------------------------------- test
    initial begin
        vec_t tbl[$];
        vec_t t, e;
        logic [AW-1:0] probe [4];

        // reset state
        t = lk("reset", 32'h1000, 0, 0, 0); t.rst = 1'b1; t.e_pv = 1'b0;
        apply(t);
        apply(t);

        tbl.push_back(lk("cold_lookup", 32'h1000, 0, 0, 0));
        tbl.push_back(rs("be_alloc", OP_BE, 32'h1000, 32'h2000, 16'h1234, 16'h1234, 0, 0, 0, 1, 1, 1, 32'h2000, 1));
        tbl.push_back(lk("hit_after_alloc", 32'h1000, 1, 32'h2000, 1));
        tbl.push_back(rs("bne_nt1", OP_BNE, 32'h1000, 32'h2000, 16'hABCD, 16'hABCD, 0, 1, 32'h2000, 0, 0, 1, 32'h1004, 2));
        tbl.push_back(rs("bne_nt2", OP_BNE, 32'h1000, 32'h2000, 16'hABCD, 16'hABCD, 0, 1, 32'h2000, 0, 0, 1, 32'h1004, 3));
        tbl.push_back(lk("decayed", 32'h1000, 0, 0, 3));
        tbl.push_back(rs("bne_t1", OP_BNE, 32'h1000, 32'h2000, 16'h0001, 16'h0002, 0, 0, 0, 1, 1, 1, 32'h2000, 4));
        tbl.push_back(rs("bne_t2", OP_BNE, 32'h1000, 32'h2000, 16'h0001, 16'h0002, 0, 0, 0, 1, 1, 1, 32'h2000, 5));
        tbl.push_back(lk("retrained", 32'h1000, 1, 32'h2000, 5));
        for (int i = 0; i < 3; i++)
            tbl.push_back(rs("bne_sat", OP_BNE, 32'h1000, 32'h2000, 16'h0001, 16'h0002, 0, 1, 32'h2000, 1, 1, 0, 0, 5));
        tbl.push_back(rs("bne_nt3", OP_BNE, 32'h1000, 32'h2000, 16'hABCD, 16'hABCD, 0, 1, 32'h2000, 0, 0, 1, 32'h1004, 6));
        tbl.push_back(lk("sat_held", 32'h1000, 1, 32'h2000, 6));
        t = rs("alias_rbw", OP_BE, 32'h1010, 32'h9000, 16'h0005, 16'h0005, 0, 0, 0, 1, 1, 1, 32'h9000, 7);
        t.fv = 1'b1; t.fpc = 32'h1000; t.e_pv = 1'b1; t.e_pt = 1'b1; t.e_ptgt = 32'h2000;
        tbl.push_back(t);
        tbl.push_back(lk("alias_old_miss", 32'h1000, 0, 0, 7));
        tbl.push_back(lk("alias_new_hit", 32'h1010, 1, 32'h9000, 7));
        tbl.push_back(rs("jsr_wrong_tgt", OP_JSR, 32'h3000, 32'h7000, 0, 0, 0, 1, 32'h6000, 1, 1, 1, 32'h7000, 8));
        tbl.push_back(rs("jsr_right_tgt", OP_JSR, 32'h3000, 32'h7000, 0, 0, 0, 1, 32'h7000, 1, 1, 0, 0, 8));
        tbl.push_back(lk("jsr_strong", 32'h3000, 1, 32'h7000, 8));
        tbl.push_back(rs("blt_sign", OP_BLT, 32'h4004, 32'h5000, 16'h8000, 16'h0001, 0, 0, 0, 0, 1, 0, 0, 8));
        tbl.push_back(rs("bgt_taken", OP_BGT, 32'h4008, 32'h5100, 16'h0030, 16'h0010, 0, 1, 32'h5100, 1, 1, 0, 0, 8));
        tbl.push_back(rs("bro_v1", OP_BRO, 32'h400C, 32'h5200, 0, 0, 1, 1, 32'h5200, 1, 1, 0, 0, 8));
        tbl.push_back(rs("bro_v0", OP_BRO, 32'h400C, 32'h5200, 0, 0, 0, 1, 32'h5200, 0, 0, 1, 32'h4010, 9));
        tbl.push_back(rs("bgt_sign", OP_BGT, 32'h4014, 32'h5300, 16'h8000, 16'h0001, 0, 0, 0, 1, 0, 1, 32'h5300, 10));
        tbl.push_back(rs("nop", OP_NOP, 32'h4014, 32'h1234, 0, 0, 0, 1, 0, 0, 0, 0, 0, 10));
        tbl.push_back(lk("nop_no_update", 32'h4014, 1, 32'h5300, 10));

        foreach (tbl[i]) apply(tbl[i]);

        // Reset arriving together with a mispredicting resolve and a lookup.
        t = rs("rst_mid", OP_BE, 32'h1000, 32'h2000, 16'h0001, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 0);
        t.rst = 1'b1; t.fv = 1'b1; t.fpc = 32'h3000;
        apply(t);
        probe[0] = 32'h3000; probe[1] = 32'h4008; probe[2] = 32'h400C; probe[3] = 32'h4014;
        for (int i = 0; i < 4; i++) apply(lk("post_rst_miss", probe[i], 0, 0, 0));

        // Randomized traffic against the model.
        model_reset();
        for (int n = 0; n < 600; n++) begin
            int idx;
            t.nm   = "rand";
            t.rst  = ($urandom_range(0, 59) == 0);
            t.fv   = $urandom_range(0, 1);
            t.fpc  = 32'h1000 + ($urandom_range(0, 2) << 4) + $urandom_range(0, 3);
            t.rv   = ($urandom_range(0, 3) != 0);
            t.op   = opcode_e'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) t.op = opcode_e'($urandom_range(8, 14));
            t.rpc  = 32'h1000 + ($urandom_range(0, 2) << 4) + $urandom_range(0, 3);
            t.tgt  = 32'h8000 + ($urandom_range(0, 3) << 8);
            t.a    = 16'($urandom_range(0, 3));
            t.b    = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) t.a[15] = 1'b1;
            if ($urandom_range(0, 3) == 0) t.b[15] = 1'b1;
            t.v    = $urandom_range(0, 1);
            idx    = int'(t.rpc % NE);
            if ($urandom_range(0, 1) == 1) begin
                t.pt   = model_hit(t.rpc) && (m_ctr[idx] >= 2);
                t.ptgt = t.pt ? m_tgt[idx] : '0;
            end else begin
                t.pt   = $urandom_range(0, 1);
                t.ptgt = 32'h8000 + ($urandom_range(0, 3) << 8);
            end
            model_step(t, e);
            apply(e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised successor to `branch_unit`. It resolves all NeoCore branch conditions, predicts fetch-stage branches and detects mispredictions. Prediction uses a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. The block sits between fetch, which does the lookups, and execute, which does the resolution, and drives the pipeline redirect on a misprediction.

## Interface
Parameters:
- ADDR_W, 32, PC/target width
- DATA_W, 16, compare operand width
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2; IDX_W = log2(BTB_ENTRIES)
- SIGNED_CMP, 0, 0 = BLT/BGT unsigned compare, 1 = two's-complement compare

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous and active-high
- f_valid  in  1  fetch lookup request
- f_pc  in  ADDR_W  fetch PC
- p_valid  out  1  prediction valid (registered f_valid)
- p_taken  out  1  predicted taken
- p_target  out  ADDR_W  predicted target; 0 when p_taken=0
- r_valid  in  1  resolve request from execute
- r_opcode  in  opcode_e  neocore_pkg opcode
- r_pc  in  ADDR_W  branch instruction PC
- r_next_pc  in  ADDR_W  fall-through PC
- r_target  in  ADDR_W  computed branch target
- r_operand_a, r_operand_b  in  DATA_W  compare operands
- r_v_flag  in  1  V flag
- r_pred_taken  in  1  prediction carried with the instruction
- r_pred_target  in  ADDR_W  carried predicted target
- branch_taken  out  1  registered actual outcome
- redirect  out  1  one-cycle mispredict pulse
- redirect_pc  out  ADDR_W  correct next PC
- mispredict_count  out  16  saturating mispredict counter

## Operation
- **BTB entry fields:** valid, tag = pc[ADDR_W-1:IDX_W], target, ctr[1:0]. The index is pc[IDX_W-1:0].
- **Lookup:**
  - A hit requires valid and tag equal.
  - p_taken = hit & ctr[1].
  - p_target = the entry target if p_taken, else 0.
- **Conditions, with a = r_operand_a and b = r_operand_b:**
  - OP_B, OP_JSR: always taken.
  - OP_BE: a==b.
  - OP_BNE: a!=b.
  - OP_BLT: a<b.
  - OP_BGT: a>b.
  - OP_BRO: r_v_flag.
  - Any other opcode is a non-branch. When r_valid is set with a non-branch opcode: no update, branch_taken=0, no redirect.
- **Update, when r_valid is set with a branch opcode:**
  - Taken with a BTB hit: ctr saturating +1 and the target is rewritten.
  - Taken with a BTB miss: allocate with valid=1, tag, target, ctr=2'b10. This overwrites any previous occupant of the index.
  - Not taken with a BTB hit: ctr saturating −1; the entry stays valid.
  - Not taken with a BTB miss: no change.
  - OP_B and OP_JSR force ctr=2'b11.
- **Mispredict** (branch opcode only) occurs when either:
  - actual ≠ r_pred_taken, or
  - actual = 1, r_pred_taken = 1 and r_pred_target ≠ r_target.
- **On a mispredict:** redirect=1, and redirect_pc = r_target if taken, else r_next_pc. mispredict_count increments and saturates at 16'hFFFF.
- **Same-index lookup and update in one cycle:** the lookup sees the pre-update contents (read-before-write).
- No internal FSM beyond the BTB array, the pipeline registers and the counter.

## Timing
- **Lookup latency:** 1 cycle; the f_valid edge produces p_valid/p_taken/p_target on the next cycle. One lookup per cycle is accepted, with no stall.
- **Resolve latency:** 1 cycle; branch_taken, redirect and redirect_pc are registered. The BTB write takes effect at the same edge, so the next cycle's lookup sees it.
- **Resolve throughput:** back-to-back resolves every cycle are accepted.
- **redirect:** high for exactly one cycle per mispredicting resolve. Consecutive mispredicts give consecutive pulses.
- **Reset values:** all outputs 0, all valid bits 0, all ctr 0, mispredict_count 0. f_valid and r_valid are ignored while rst=1.
- **Reset mid-operation:** a rst asserted in the same cycle as r_valid discards that update. The next-cycle outputs are 0.

## Test plan
- **Cold miss:** after reset, f_pc=0x1000 → p_valid=1, p_taken=0. Then resolve OP_BE at r_pc=0x1000 with a=b=0x1234, r_target=0x2000, r_pred_taken=0 → branch_taken=1, redirect=1, redirect_pc=0x2000, mispredict_count=1. Then lookup 0x1000 → p_taken=1, p_target=0x2000.
- **Counter saturation/decay:** with the entry at ctr=10, resolve OP_BNE not-taken (a=b=0xABCD) twice → lookup p_taken=0, each resolve redirecting to r_next_pc. Two taken resolves → p_taken=1. Three more taken resolves → ctr stays 11.
- **Wrong target:** OP_JSR r_pc=0x3000, r_target=0x7000, r_pred_taken=1, r_pred_target=0x6000 → redirect=1, redirect_pc=0x7000. Resolve again with r_pred_target=0x7000 → no redirect.
- **Compare modes:**
  - SIGNED_CMP=0, OP_BLT a=0x8000, b=0x0001 → branch_taken=0.
  - SIGNED_CMP=1, same operands → branch_taken=1.
  - OP_BGT a=0x0030, b=0x0010 → taken.
  - OP_BRO V=1 → taken; V=0 → not taken.
- **Aliasing/conflict:** with BTB_ENTRIES=16, the entry at 0x1000 is replaced by a taken resolve at 0x1010 with target 0x9000 → lookup 0x1000 misses, lookup 0x1010 hits. A simultaneous lookup+update on the same index returns the old entry.
- **Reset/non-branch:** r_valid with OP_NOP → no update, branch_taken=0, no redirect. Assert rst with r_valid mispredicting → redirect=0, mispredict_count=0, all BTB entries invalid.
